// File: rtl/wb_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg_pkg
// Shared definitions for the MEM->WB stage register and the hazard unit:
// write-data source codes, the default link offset, default widths and the
// default-width entry record.
// -----------------------------------------------------------------------------
package wb_stage_reg_pkg;

    localparam int DW_DEF       = 32;
    localparam int AW_DEF       = 5;
    localparam int TW_DEF       = 3;
    localparam int LINK_OFS_DEF = 8;

    // Write-data source select
    typedef enum logic [1:0] {
        WD_DR = 2'd0,
        WD_AO = 2'd1,
        WD_PC = 2'd2,
        WD_MD = 2'd3
    } wd_sel_e;

    // One held instruction at default widths (as seen by the hazard unit)
    typedef struct packed {
        logic [DW_DEF-1:0] ir;
        logic [DW_DEF-1:0] pc;
        logic [DW_DEF-1:0] dr;
        logic [DW_DEF-1:0] ao;
        logic [AW_DEF-1:0] a3;
        logic [TW_DEF-1:0] tnew;
        logic [DW_DEF-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_reg_wd_mux.sv
// -----------------------------------------------------------------------------
// wb_stage_reg_wd_mux
// Combinational write-data select, including the link-address adder.
// Ports:
//   sel  in  2   write-data source (wd_sel_e)
//   pc   in  DW  instruction PC
//   dr   in  DW  memory read data
//   ao   in  DW  ALU result
//   md   in  DW  mult/div result
//   wd   out DW  selected write data
// -----------------------------------------------------------------------------
module wb_stage_reg_wd_mux
    import wb_stage_reg_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int LINK_OFS = LINK_OFS_DEF
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] dr,
    input  logic [DW-1:0] ao,
    input  logic [DW-1:0] md,
    output logic [DW-1:0] wd
);

    always_comb begin
        wd = dr;
        case (wd_sel_e'(sel))
            WD_DR: wd = dr;
            WD_AO: wd = ao;
            // Link address; carry out of the top bit is dropped
            WD_PC: wd = pc + DW'(LINK_OFS);
            WD_MD: wd = md;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg
// MEM->WB pipeline register with valid/ready handshake and a one-entry skid
// buffer. Write data is resolved at capture; Tnew ages by one (saturating at
// zero) on every edge an instruction is held. flush kills both entries.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid / in_ready              upstream handshake
//   ir, pc, dr, ao, md, a3, tnew,
//   wd_sel                           MEM-stage beat
//   flush                            synchronous kill of held entries
//   out_valid / out_ready            downstream handshake (main entry)
//   ir_w, pc_w, dr_w, ao_w, wd_w,
//   a3_w, tnew_w, reg_we_w           main-entry payload to writeback/hazard
// -----------------------------------------------------------------------------
module wb_stage_reg
    import wb_stage_reg_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int TW       = TW_DEF,
    parameter int LINK_OFS = LINK_OFS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] ir,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] dr,
    input  logic [DW-1:0] ao,
    input  logic [DW-1:0] md,
    input  logic [AW-1:0] a3,
    input  logic [TW-1:0] tnew,
    input  logic [1:0]    wd_sel,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] ir_w,
    output logic [DW-1:0] pc_w,
    output logic [DW-1:0] dr_w,
    output logic [DW-1:0] ao_w,
    output logic [DW-1:0] wd_w,
    output logic [AW-1:0] a3_w,
    output logic [TW-1:0] tnew_w,
    output logic          reg_we_w
);

    typedef struct packed {
        logic [DW-1:0] ir;
        logic [DW-1:0] pc;
        logic [DW-1:0] dr;
        logic [DW-1:0] ao;
        logic [AW-1:0] a3;
        logic [TW-1:0] tnew;
        logic [DW-1:0] wd;
    } entry_t;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    logic [DW-1:0] wd_p0;
    entry_t        beat_p0;
    entry_t        main_p1;
    entry_t        skid_p1;
    logic          vld_main_p1;
    logic          vld_skid_p1;
    logic          accept;
    logic          pop;

    // ---- Stage p0: capture-side resolution of the incoming beat ----
    wb_stage_reg_wd_mux #(
        .DW       (DW),
        .LINK_OFS (LINK_OFS)
    ) u_wd_mux (
        .sel (wd_sel),
        .pc  (pc),
        .dr  (dr),
        .ao  (ao),
        .md  (md),
        .wd  (wd_p0)
    );

    always_comb begin
        beat_p0      = '0;
        beat_p0.ir   = ir;
        beat_p0.pc   = pc;
        beat_p0.dr   = dr;
        beat_p0.ao   = ao;
        beat_p0.a3   = a3;
        beat_p0.tnew = sat_dec(tnew);
        beat_p0.wd   = wd_p0;
    end

    // in_ready looks only at registered skid state, never at out_ready
    assign in_ready = rst_n && !vld_skid_p1 && !flush;
    assign accept   = in_valid && in_ready;
    assign pop      = vld_main_p1 && out_ready;

    // ---- Stage p1: main and skid entries ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_p1     <= '0;
            skid_p1     <= '0;
            vld_main_p1 <= 1'b0;
            vld_skid_p1 <= 1'b0;
        end else if (flush) begin
            main_p1     <= '0;
            skid_p1     <= '0;
            vld_main_p1 <= 1'b0;
            vld_skid_p1 <= 1'b0;
        end else if (!vld_main_p1 || (pop && !vld_skid_p1)) begin
            // Main free this edge: take the beat or go empty (zeroed fields)
            vld_main_p1 <= accept;
            main_p1     <= accept ? beat_p0 : '0;
        end else if (pop) begin
            // Skid drains into main; no beat was accepted since in_ready was 0
            main_p1      <= skid_p1;
            main_p1.tnew <= sat_dec(skid_p1.tnew);
            skid_p1      <= '0;
            vld_skid_p1  <= 1'b0;
        end else begin
            // Main held: age it; absorb one beat into skid, or age a held skid
            main_p1.tnew <= sat_dec(main_p1.tnew);
            if (accept) begin
                skid_p1     <= beat_p0;
                vld_skid_p1 <= 1'b1;
            end else if (vld_skid_p1) begin
                skid_p1.tnew <= sat_dec(skid_p1.tnew);
            end
        end
    end

    assign out_valid = vld_main_p1;
    assign ir_w      = main_p1.ir;
    assign pc_w      = main_p1.pc;
    assign dr_w      = main_p1.dr;
    assign ao_w      = main_p1.ao;
    assign wd_w      = main_p1.wd;
    // Fields are zeroed whenever main is empty, so these read 0 when invalid
    assign a3_w      = main_p1.a3;
    assign tnew_w    = main_p1.tnew;
    assign reg_we_w  = vld_main_p1 && (main_p1.a3 != '0);

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir, pc, dr, ao, md;
    logic [4:0]  a3;
    logic [2:0]  tnew;
    logic [1:0]  wd_sel;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ir_w, pc_w, dr_w, ao_w, wd_w;
    logic [4:0]  a3_w;
    logic [2:0]  tnew_w;
    logic        reg_we_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_stage_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .pc        (pc),
        .dr        (dr),
        .ao        (ao),
        .md        (md),
        .a3        (a3),
        .tnew      (tnew),
        .wd_sel    (wd_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ir_w      (ir_w),
        .pc_w      (pc_w),
        .dr_w      (dr_w),
        .ao_w      (ao_w),
        .wd_w      (wd_w),
        .a3_w      (a3_w),
        .tnew_w    (tnew_w),
        .reg_we_w  (reg_we_w)
    );

    // Advance one rising edge and settle 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] i_ir, input logic [31:0] i_pc,
                            input logic [1:0] i_sel, input logic [4:0] i_a3,
                            input logic [2:0] i_tnew);
        in_valid = 1'b1;
        ir       = i_ir;
        pc       = i_pc;
        wd_sel   = i_sel;
        a3       = i_a3;
        tnew     = i_tnew;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        ir = '0; pc = '0; dr = '0; ao = '0; md = '0; a3 = '0; tnew = '0; wd_sel = '0;
        step(); step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || wd_w !== 32'h0 || a3_w !== 5'h0 || reg_we_w !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b wd_w=%h a3_w=%h reg_we=%b, want 0 0 0 0 0",
                     out_valid, in_ready, wd_w, a3_w, reg_we_w);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_wd [4];
        exp_wd[0] = 32'h1111_1111;
        exp_wd[1] = 32'h2222_2222;
        exp_wd[2] = 32'h0000_3008;
        exp_wd[3] = 32'h4444_4444;
        dr = 32'h1111_1111; ao = 32'h2222_2222; md = 32'h4444_4444;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(32'hA000_0000 + k, 32'h0000_3000, 2'(k), 5'd7, 3'd0);
            step();
            tests++;
            if (out_valid !== 1'b1 || wd_w !== exp_wd[k] || ir_w !== 32'hA000_0000 + k || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_%0d: out_valid=%b wd_w=%h ir_w=%h in_ready=%b, want 1 %h %h 1",
                         k, out_valid, wd_w, ir_w, in_ready, exp_wd[k], 32'hA000_0000 + k);
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || wd_w !== 32'h0 || a3_w !== 5'd0) begin
            fails++;
            $display("FAIL stream_drain: out_valid=%b wd_w=%h a3_w=%h, want 0 0 0", out_valid, wd_w, a3_w);
        end
    endtask

    task automatic test_stall_skid();
        logic [2:0] exp_t [4];
        exp_t[0] = 3'd2; exp_t[1] = 3'd1; exp_t[2] = 3'd0; exp_t[3] = 3'd0;
        out_ready = 1'b0;
        dr = 32'h0000_00AA;
        set_beat(32'hB000_000A, 32'h0000_4000, 2'd0, 5'd5, 3'd3);
        for (int k = 0; k < 4; k++) begin
            step();
            // After the first edge, offer beat B (absorbed into skid), then C (refused)
            if (k == 0) set_beat(32'hB000_000B, 32'h0000_4004, 2'd0, 5'd6, 3'd3);
            else        set_beat(32'hB000_000C, 32'h0000_4008, 2'd0, 5'd7, 3'd3);
            tests++;
            if (out_valid !== 1'b1 || ir_w !== 32'hB000_000A || tnew_w !== exp_t[k]) begin
                fails++;
                $display("FAIL stall_hold_%0d: out_valid=%b ir_w=%h tnew_w=%0d, want 1 b000000a %0d",
                         k, out_valid, ir_w, tnew_w, exp_t[k]);
            end
            tests++;
            if (in_ready !== (k == 0)) begin
                fails++;
                $display("FAIL stall_ready_%0d: in_ready=%b want %b", k, in_ready, (k == 0));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || ir_w !== 32'hB000_000B || a3_w !== 5'd6 || tnew_w !== 3'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL skid_to_main: out_valid=%b ir_w=%h a3_w=%0d tnew_w=%0d in_ready=%b, want 1 b000000b 6 0 1",
                     out_valid, ir_w, a3_w, tnew_w, in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || ir_w !== 32'h0) begin
            fails++;
            $display("FAIL stall_drain: out_valid=%b ir_w=%h, want 0 0", out_valid, ir_w);
        end
    endtask

    task automatic test_pc_wrap();
        out_ready = 1'b1;
        set_beat(32'hC000_0001, 32'hFFFF_FFFC, 2'd2, 5'd31, 3'd1);
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || wd_w !== 32'h0000_0004 || pc_w !== 32'hFFFF_FFFC || tnew_w !== 3'd0) begin
            fails++;
            $display("FAIL pc_wrap: out_valid=%b wd_w=%h pc_w=%h tnew_w=%0d, want 1 00000004 fffffffc 0",
                     out_valid, wd_w, pc_w, tnew_w);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_beat(32'hD000_0001, 32'h0000_5000, 2'd1, 5'd9, 3'd2);
        step();
        set_beat(32'hD000_0002, 32'h0000_5004, 2'd1, 5'd10, 3'd2);
        step();
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_setup: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
        end
        flush = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready_low: in_ready=%b want 0", in_ready);
        end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || a3_w !== 5'd0 || tnew_w !== 3'd0 || reg_we_w !== 1'b0 || in_ready !== 1'b1 || ir_w !== 32'h0) begin
            fails++;
            $display("FAIL flush_clear: out_valid=%b a3_w=%0d tnew_w=%0d reg_we=%b in_ready=%b ir_w=%h, want 0 0 0 0 1 0",
                     out_valid, a3_w, tnew_w, reg_we_w, in_ready, ir_w);
        end
        // Skid must also be empty: after one fresh beat, nothing else follows
        out_ready = 1'b1;
        set_beat(32'hD000_0003, 32'h0000_5008, 2'd1, 5'd11, 3'd0);
        step();
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_skid_empty: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reg_we();
        out_ready = 1'b1;
        set_beat(32'hE000_0000, 32'h0000_6000, 2'd1, 5'd0, 3'd0);
        step();
        tests++;
        if (out_valid !== 1'b1 || reg_we_w !== 1'b0) begin
            fails++;
            $display("FAIL reg_we_a3_zero: out_valid=%b reg_we=%b, want 1 0", out_valid, reg_we_w);
        end
        set_beat(32'hE000_0001, 32'h0000_6004, 2'd1, 5'd31, 3'd0);
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || reg_we_w !== 1'b1 || a3_w !== 5'd31) begin
            fails++;
            $display("FAIL reg_we_a3_31: out_valid=%b reg_we=%b a3_w=%0d, want 1 1 31", out_valid, reg_we_w, a3_w);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        dr = 32'h0000_0077;
        set_beat(32'hF000_0001, 32'h0000_7000, 2'd0, 5'd3, 3'd0);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || ir_w !== 32'h0 || wd_w !== 32'h0 || a3_w !== 5'd0 || reg_we_w !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b ir_w=%h wd_w=%h a3_w=%0d reg_we=%b, want 0 0 0 0 0 0",
                     out_valid, in_ready, ir_w, wd_w, a3_w, reg_we_w);
        end
        step();
        rst_n = 1'b1;
        set_beat(32'hF000_0002, 32'h0000_7004, 2'd0, 5'd4, 3'd0);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || ir_w !== 32'hF000_0002 || wd_w !== 32'h0000_0077) begin
            fails++;
            $display("FAIL post_reset_accept: out_valid=%b ir_w=%h wd_w=%h, want 1 f0000002 00000077",
                     out_valid, ir_w, wd_w);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_pc_wrap();
        test_flush();
        test_reg_we();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised MEM→WB pipeline stage register for the pipelined MIPS core. It has a valid/ready handshake and a one-entry skid buffer, so the writeback stage can stall without stalling memory combinationally. It resolves the register write data at capture time, counts Tnew down each cycle an instruction is held, and supports a synchronous flush. Its outputs feed the register file write port and the hazard/forwarding unit.

## Interface
- DW, 32: datapath width (IR, PC, DR, AO, MD, WD).
- AW, 5: destination register address width.
- TW, 3: Tnew counter width.
- LINK_OFS, 8: link offset added to PC for WDSel = PC.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; = rst_n && !skid_v && !flush.
- ir, pc, dr, ao, md  in  DW  instruction, PC, memory read data, ALU result, mult/div result.
- a3  in  AW  destination register.
- tnew  in  TW  cycles until the result is ready, as seen at MEM.
- wd_sel  in  2  write-data source: DR=0, AO=1, PC=2, MD=3.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  main entry valid.
- out_ready  in  1  writeback consumes main entry.
- ir_w, pc_w, dr_w, ao_w, wd_w  out  DW  main-entry payload and resolved write data.
- a3_w  out  AW  main-entry destination; 0 when invalid.
- tnew_w  out  TW  main-entry Tnew; 0 when invalid.
- reg_we_w  out  1  out_valid && a3_w != 0.

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each has a valid bit plus fields {ir, pc, dr, ao, a3, tnew, wd}.
- Capture: on accept (in_valid && in_ready), wd = mux(wd_sel): DR→dr, AO→ao, PC→pc+LINK_OFS (mod 2^DW, carry dropped), MD→md. Stored tnew = sat0(tnew−1). md itself is not stored.
- Pop = out_valid && out_ready.
- Per edge, with flush=0:
  - Main empty, or popping with skid empty: an accepted beat loads main; with no beat, main clears to all-zero/invalid.
  - Popping with skid full: skid moves to main and skid becomes empty. in_ready was 0, so no beat was accepted.
  - Main full, not popping: an accepted beat loads skid.
- Hold aging: every edge an entry stays resident (main not popped, or skid kept, or skid→main move), its tnew = sat0(tnew−1). Tnew never wraps below 0.
- Flush: has priority over everything. Both valids and all fields clear to 0 at the edge. in_ready is 0 during flush, so no beat is lost silently. A pop in the flush cycle is still reported to writeback, because out_valid was 1.
- Reset (rst_n=0, asynchronous): all registers clear to 0 and in_ready=0. The first accept is possible in the first cycle with rst_n=1.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready depends only on registered skid_v plus rst_n and flush. There is no combinational path from out_ready to in_ready.
- Outputs are purely registered.
- After out_ready deasserts, exactly one further beat can be absorbed; in_ready drops the next cycle.
- Reset values: all outputs 0; in_ready 0 while rst_n=0.

## Structure
- Shared package: WDSel codes (DR, AO, PC, MD), the LINK_OFS default, and the entry struct typedef {ir, pc, dr, ao, a3, tnew, wd}. The same package is used by the hazard unit.
- Sub-module: wd_mux, the combinational write-data select including the PC+LINK_OFS adder. Entry storage and control are inline.

## Test plan
- Reset mid-stream: hold an entry, pull rst_n low asynchronously between edges → all outputs 0 immediately and in_ready=0; after release, accept resumes next cycle.
- Streaming: 4 beats with out_ready=1, wd_sel cycling DR/AO/PC/MD, pc=0x3000 → wd_w = dr, ao, 0x3008, md in order, one per cycle.
- Stall with skid: out_ready=0 for 3 cycles while in_valid=1, tnew=3 → second beat enters skid and in_ready=0. Main tnew_w goes 2,1,0,0 (saturates). After release, skid beat appears next with its aged tnew.
- PC wrap: pc=0xFFFF_FFFC, wd_sel=PC → wd_w=0x0000_0004.
- Flush while both entries full → next cycle out_valid=0, a3_w=0, tnew_w=0, reg_we_w=0, in_ready=1.
- a3=0 beat: out_valid=1 with reg_we_w=0; a3=31 → reg_we_w=1.
